serial_sipo_fifo: RTL and testbench
===================================

// Module: serial_sipo_fifo
// PURPOSE
//  Multi-lane serial-in, parallel-out message assembler with an internal message FIFO.
//  - Collects LANES bits per accepted beat into one message of 1..MAXLEN bits, closed by lastin.
//  - Queues up to DEPTH completed messages.
//  - Presents each queued message on dataout/lenout, one per pull.
//  - Successor of the 1-bit/64-bit serial block: adds lane width, bit order, input backpressure,
//    an occupancy count and length-error reporting.
// PARAMETERS
//  MAXLEN    64  maximum message length in bits (>=2)
//  LANES     1   bits per input beat (1, 2, 4 or 8; must divide MAXLEN)
//  DEPTH     32  completed messages held, output register included (>=2)
//  LSB_FIRST 0   0: first bit received lands at dataout[len-1]; 1: first bit at dataout[0]
//  Derived widths: LENW=$clog2(MAXLEN+1), LCW=max(1,$clog2(LANES)), CNTW=$clog2(DEPTH+1)
// PORTS
//  clk      in   1       clock, rising edge
//  rst      in   1       asynchronous active-low reset (0 = reset)
//  pushin   in   1       input beat valid
//  lastin   in   1       beat is the final beat of the message
//  datain   in   LANES   beat data; datain[LANES-1] is earliest in time
//  lastcnt  in   LCW     on a lastin beat: valid lanes minus 1 (top lanes first); ignored if LANES=1
//  stopin   out  1       1: FIFO full, beats not accepted
//  pullout  in   1       consumer takes the presented message
//  stopout  out  1       1: no message presented
//  dataout  out  MAXLEN  message bits, right-justified, unused upper bits 0
//  lenout   out  LENW    message length in bits, 1..MAXLEN
//  count    out  CNTW    completed messages held, 0..DEPTH
//  errlen   out  1       sticky: a message exceeded MAXLEN bits
// BEHAVIOUR
//  - Reset (async assert, sync release): stopin=0, stopout=1, dataout=0, lenout=0, count=0,
//    errlen=0. A partial message, the FIFO and all flags are discarded. A message interrupted
//    mid-way by reset is never output.
//  - All outputs come straight from flops. No combinational path from any input to any output.
//  - Beat accepted at a posedge iff pushin=1 && stopin=0. Beats offered while stopin=1 are
//    ignored; the sender holds them. Non-last beats add LANES bits. A last beat adds lastcnt+1 bits.
//  - Bit order (LSB_FIRST=0): each new bit shifts in at bit 0, so the earliest bit ends at
//    dataout[len-1]. For LSB_FIRST=1, the k-th bit received (k from 0) goes to dataout[k].
//  - Length overrun: bits past MAXLEN are dropped and errlen sets (sticky until reset). The
//    message still commits at lastin with lenout=MAXLEN and contains the first MAXLEN bits.
//  - Commit: the message is written to the FIFO at the edge that accepts the lastin beat. The
//    assembler is empty for the next beat at the following edge, with no dead cycle.
//  - Latency: with the FIFO empty, lastin accepted at edge N gives stopout=0 with that message
//    on dataout/lenout after edge N+1.
//  - Pull: a transfer occurs at a posedge where stopout=0 && pullout=1. After that edge the next
//    message is presented, or stopout=1 if none is left. Back-to-back pulls run at 1 per cycle.
//    pullout is ignored while stopout=1. dataout/lenout hold while stopout=0 with no transfer.
//  - count increments on commit and decrements on transfer; it is unchanged when both happen at
//    the same edge. stopin = (count==DEPTH), registered.
//  - Full with a simultaneous pull: stopin was already 1, so there is no commit that edge. stopin
//    falls after that edge. There is no overflow path.
//  - FIFO read and write pointers wrap modulo DEPTH. DEPTH need not be a power of 2.
//  - Message order is strictly preserved.
// TESTING
//  1 MAXLEN=64, LANES=1: send 7 bits 1011001 MSB-first, pullout held 1
//    -> one transfer, dataout=64'h59, lenout=7.
//  2 LANES=4, LSB_FIRST=0: beats 4'hA, 4'h3, then last beat 4'hC with lastcnt=1
//    -> dataout=10'b1010_0011_11, lenout=10.
//  3 DEPTH=4, pullout=0: send 5 one-bit messages
//    -> stopin=1 once count=4 and the 5th beat is held. Pull once -> stopin=0, 5th message
//    commits, count returns to 4.
//  4 Send a 70-bit message on MAXLEN=64
//    -> lenout=64, dataout is the first 64 bits, errlen=1 and stays 1 for later good messages.
//  5 Assert rst low mid-message with 2 messages queued
//    -> stopout=1 and count=0 immediately. After release, a fresh 3-bit message 101 comes out
//    alone as dataout=5, lenout=3.
//  6 Random lengths 1..64, random pushin gaps, random pullout, 100k messages
//    -> scoreboard matches data and length in order. Outputs are stable 0.08 ns after each edge.

Source files
------------

// File: rtl/serial_sipo_fifo.sv
// ---------------------------------------------------------------------------
// serial_sipo_fifo
//   Multi-lane serial-in, parallel-out message assembler feeding a message
//   FIFO. Each accepted beat contributes LANES bits (or lastcnt+1 bits on the
//   closing beat) to the message being assembled. The closing beat commits
//   the message, with its length, into the FIFO. The consumer pulls one
//   message at a time from a registered output stage.
//
// Ports
//   clk      in   1       rising-edge clock
//   rst      in   1       asynchronous active-low reset
//   pushin   in   1       input beat valid
//   lastin   in   1       beat closes the message
//   datain   in   LANES   beat data, datain[LANES-1] is earliest in time
//   lastcnt  in   LCW     valid lanes minus 1 on a closing beat (top lanes)
//   stopin   out  1       FIFO full, beats are not accepted
//   pullout  in   1       consumer takes the presented message
//   stopout  out  1       no message presented
//   dataout  out  MAXLEN  message bits, right-justified, upper bits zero
//   lenout   out  LENW    message length in bits
//   count    out  CNTW    completed messages held (output stage included)
//   errlen   out  1       sticky: some message was longer than MAXLEN
// ---------------------------------------------------------------------------
module serial_sipo_fifo #(
  parameter int MAXLEN    = 64,
  parameter int LANES     = 1,
  parameter int DEPTH     = 32,
  parameter bit LSB_FIRST = 1'b0,
  localparam int LENW = $clog2(MAXLEN + 1),
  localparam int LCW  = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int CNTW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pushin,
  input  logic              lastin,
  input  logic [LANES-1:0]  datain,
  input  logic [LCW-1:0]    lastcnt,
  output logic              stopin,
  input  logic              pullout,
  output logic              stopout,
  output logic [MAXLEN-1:0] dataout,
  output logic [LENW-1:0]   lenout,
  output logic [CNTW-1:0]   count,
  output logic              errlen
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW   = $clog2(LANES + 1);
  localparam int WW   = LENW + MAXLEN;

  localparam logic [LENW-1:0]   LEN_ZERO  = LENW'(0);
  localparam logic [LENW-1:0]   LEN_ONE   = LENW'(1);
  localparam logic [LENW-1:0]   LEN_MAX   = LENW'(MAXLEN);
  localparam logic [CNTW-1:0]   CNT_ZERO  = CNTW'(0);
  localparam logic [CNTW-1:0]   CNT_ONE   = CNTW'(1);
  localparam logic [CNTW-1:0]   CNT_FULL  = CNTW'(DEPTH);
  localparam logic [PTRW-1:0]   PTR_ZERO  = PTRW'(0);
  localparam logic [PTRW-1:0]   PTR_ONE   = PTRW'(1);
  localparam logic [PTRW-1:0]   PTR_LAST  = PTRW'(DEPTH - 1);
  localparam logic [BW-1:0]     BW_ONE    = BW'(1);
  localparam logic [BW-1:0]     BEAT_FULL = BW'(LANES);
  localparam logic [MAXLEN-1:0] DATA_ZERO = MAXLEN'(0);
  localparam logic [MAXLEN-1:0] DATA_ONE  = MAXLEN'(1);

  // Pointer advance modulo DEPTH; DEPTH need not be a power of two.
  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    if (p == PTR_LAST) begin
      ptr_inc = PTR_ZERO;
    end else begin
      ptr_inc = p + PTR_ONE;
    end
  endfunction

  // Assembler state
  logic [MAXLEN-1:0] asm_data_r;
  logic [LENW-1:0]   asm_len_r;
  logic              errlen_r;

  // FIFO storage and bookkeeping. mem_cnt_r counts messages still in the
  // storage array; count_r also includes the one held in the output stage.
  logic [WW-1:0]     mem_r [DEPTH];
  logic [PTRW-1:0]   wr_ptr_r;
  logic [PTRW-1:0]   rd_ptr_r;
  logic [CNTW-1:0]   mem_cnt_r;
  logic [CNTW-1:0]   count_r;
  logic              stopin_r;

  // Output stage
  logic              stopout_r;
  logic [MAXLEN-1:0] dataout_r;
  logic [LENW-1:0]   lenout_r;

  // Combinational helpers
  logic              acc_s;
  logic              commit_s;
  logic              xfer_s;
  logic              load_s;
  logic [BW-1:0]     beat_bits_s;
  logic [MAXLEN-1:0] nxt_data_s;
  logic [LENW-1:0]   nxt_len_s;
  logic              ovf_s;
  logic [LANES-1:0]  beat_sh_s;
  logic [CNTW-1:0]   count_nxt_s;
  logic [CNTW-1:0]   mem_cnt_nxt_s;
  logic [WW-1:0]     rd_word_s;

  assign acc_s     = pushin & ~stopin_r;
  assign commit_s  = acc_s & lastin;
  assign xfer_s    = ~stopout_r & pullout;
  // The output stage refills whenever it is empty or being emptied.
  assign load_s    = (mem_cnt_r != CNT_ZERO) & (stopout_r | xfer_s);
  assign rd_word_s = mem_r[rd_ptr_r];

  // Number of bits carried by the current beat.
  always_comb begin
    beat_bits_s = BEAT_FULL;
    if ((LANES > 1) && lastin) begin
      beat_bits_s = BW'(lastcnt) + BW_ONE;
    end else begin
      beat_bits_s = BEAT_FULL;
    end
  end

  // Fold the beat into the assembler one bit at a time, earliest lane first.
  // Bits beyond MAXLEN are dropped and flagged.
  always_comb begin
    nxt_data_s = asm_data_r;
    nxt_len_s  = asm_len_r;
    ovf_s      = 1'b0;
    beat_sh_s  = datain;
    for (int i = 0; i < LANES; i++) begin
      if (acc_s && (i < int'(beat_bits_s))) begin
        if (nxt_len_s < LEN_MAX) begin
          if (LSB_FIRST) begin
            // k-th received bit lands at position k
            if (beat_sh_s[LANES-1]) begin
              nxt_data_s = nxt_data_s | (DATA_ONE << nxt_len_s);
            end else begin
              nxt_data_s = nxt_data_s;
            end
          end else begin
            // new bits enter at bit 0, pushing earlier bits upward
            nxt_data_s = {nxt_data_s[MAXLEN-2:0], beat_sh_s[LANES-1]};
          end
          nxt_len_s = nxt_len_s + LEN_ONE;
        end else begin
          ovf_s = 1'b1;
        end
      end else begin
        ovf_s = ovf_s;
      end
      beat_sh_s = beat_sh_s << 1'b1;
    end
  end

  // Next occupancy values for the whole FIFO and for the storage array.
  always_comb begin
    count_nxt_s   = count_r;
    mem_cnt_nxt_s = mem_cnt_r;
    if (commit_s && !xfer_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (xfer_s && !commit_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
    if (commit_s && !load_s) begin
      mem_cnt_nxt_s = mem_cnt_r + CNT_ONE;
    end else if (load_s && !commit_s) begin
      mem_cnt_nxt_s = mem_cnt_r - CNT_ONE;
    end else begin
      mem_cnt_nxt_s = mem_cnt_r;
    end
  end

  // Assembler registers and the sticky length-error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_data_r <= DATA_ZERO;
      asm_len_r  <= LEN_ZERO;
      errlen_r   <= 1'b0;
    end else begin
      if (commit_s) begin
        asm_data_r <= DATA_ZERO;
        asm_len_r  <= LEN_ZERO;
      end else if (acc_s) begin
        asm_data_r <= nxt_data_s;
        asm_len_r  <= nxt_len_s;
      end
      errlen_r <= errlen_r | ovf_s;
    end
  end

  // Message storage; contents need no reset, validity is tracked by counters.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      mem_r[wr_ptr_r] <= {nxt_len_s, nxt_data_s};
    end
  end

  // Pointers, occupancy and the registered full flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r  <= PTR_ZERO;
      rd_ptr_r  <= PTR_ZERO;
      mem_cnt_r <= CNT_ZERO;
      count_r   <= CNT_ZERO;
      stopin_r  <= 1'b0;
    end else begin
      if (commit_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (load_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      mem_cnt_r <= mem_cnt_nxt_s;
      count_r   <= count_nxt_s;
      stopin_r  <= (count_nxt_s == CNT_FULL);
    end
  end

  // Output stage: holds the presented message until it is pulled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stopout_r <= 1'b1;
      dataout_r <= DATA_ZERO;
      lenout_r  <= LEN_ZERO;
    end else begin
      if (load_s) begin
        stopout_r <= 1'b0;
        dataout_r <= rd_word_s[MAXLEN-1:0];
        lenout_r  <= rd_word_s[WW-1:MAXLEN];
      end else if (xfer_s) begin
        stopout_r <= 1'b1;
      end
    end
  end

  assign stopin  = stopin_r;
  assign stopout = stopout_r;
  assign dataout = dataout_r;
  assign lenout  = lenout_r;
  assign count   = count_r;
  assign errlen  = errlen_r;

endmodule

// File: tb/tb_serial_sipo_fifo.sv
// ---------------------------------------------------------------------------
// tb_serial_sipo_fifo
//   Three instances of serial_sipo_fifo:
//     a: MAXLEN=64, LANES=1, DEPTH=4, MSB-first
//     b: MAXLEN=64, LANES=4, DEPTH=4, MSB-first
//     c: MAXLEN=8,  LANES=4, DEPTH=3, LSB-first
//   Stimulus pushes hand-computed expected messages into per-instance
//   queues; a monitor pops and compares whenever a transfer is about to
//   happen (stopout=0 and pullout=1, sampled at the falling edge).
// ---------------------------------------------------------------------------
module tb_serial_sipo_fifo;

  typedef struct packed {
    logic [63:0] d;
    logic [63:0] l;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_push, a_last, a_pull, a_stopin, a_stopout, a_err;
  logic [0:0]  a_din, a_lc;
  logic [63:0] a_dout;
  logic [6:0]  a_len;
  logic [2:0]  a_cnt;

  logic        b_push, b_last, b_pull, b_stopin, b_stopout, b_err;
  logic [3:0]  b_din;
  logic [1:0]  b_lc;
  logic [63:0] b_dout;
  logic [6:0]  b_len;
  logic [2:0]  b_cnt;

  logic        c_push, c_last, c_pull, c_stopin, c_stopout, c_err;
  logic [3:0]  c_din;
  logic [1:0]  c_lc;
  logic [7:0]  c_dout;
  logic [3:0]  c_len;
  logic [1:0]  c_cnt;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int n_chk  = 0;
  int n_fail = 0;
  logic tog_b = 1'b0;
  logic tog_c = 1'b0;

  serial_sipo_fifo #(.MAXLEN(64), .LANES(1), .DEPTH(4), .LSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst(rst), .pushin(a_push), .lastin(a_last), .datain(a_din),
    .lastcnt(a_lc), .stopin(a_stopin), .pullout(a_pull), .stopout(a_stopout),
    .dataout(a_dout), .lenout(a_len), .count(a_cnt), .errlen(a_err));

  serial_sipo_fifo #(.MAXLEN(64), .LANES(4), .DEPTH(4), .LSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst), .pushin(b_push), .lastin(b_last), .datain(b_din),
    .lastcnt(b_lc), .stopin(b_stopin), .pullout(b_pull), .stopout(b_stopout),
    .dataout(b_dout), .lenout(b_len), .count(b_cnt), .errlen(b_err));

  serial_sipo_fifo #(.MAXLEN(8), .LANES(4), .DEPTH(3), .LSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst(rst), .pushin(c_push), .lastin(c_last), .datain(c_din),
    .lastcnt(c_lc), .stopin(c_stopin), .pullout(c_pull), .stopout(c_stopout),
    .dataout(c_dout), .lenout(c_len), .count(c_cnt), .errlen(c_err));

  function automatic exp_t mk(input logic [63:0] d, input int l);
    exp_t e;
    e.d = d;
    e.l = 64'(l);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a transfer happens at the next rising edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst === 1'b1 && a_stopout === 1'b0 && a_pull === 1'b1) begin
      if (qa.size() == 0) begin
        check("a_unexpected_msg", 64'(a_len), 64'd0);
      end else begin
        e = qa.pop_front();
        check("a_data", a_dout, e.d);
        check("a_len", 64'(a_len), e.l);
      end
    end
    if (rst === 1'b1 && b_stopout === 1'b0 && b_pull === 1'b1) begin
      if (qb.size() == 0) begin
        check("b_unexpected_msg", 64'(b_len), 64'd0);
      end else begin
        e = qb.pop_front();
        check("b_data", b_dout, e.d);
        check("b_len", 64'(b_len), e.l);
      end
    end
    if (rst === 1'b1 && c_stopout === 1'b0 && c_pull === 1'b1) begin
      if (qc.size() == 0) begin
        check("c_unexpected_msg", 64'(c_len), 64'd0);
      end else begin
        e = qc.pop_front();
        check("c_data", 64'(c_dout), e.d);
        check("c_len", 64'(c_len), e.l);
      end
    end
  end

  // Beat tasks: called just after a rising edge, return just after the
  // rising edge that accepted the beat.
  task automatic beat_a(input logic b, input logic l);
    int w = 0;
    a_push = 1'b1; a_din = b; a_last = l;
    while (a_stopin === 1'b1 && w < 100) begin @(posedge clk); #1; w++; end
    if (w >= 100) check("a_beat_timeout", 64'(w), 64'd0);
    @(posedge clk); #1;
    a_push = 1'b0; a_last = 1'b0;
  endtask

  task automatic beat_b(input logic [3:0] d, input logic l, input logic [1:0] lc);
    int w = 0;
    b_push = 1'b1; b_din = d; b_last = l; b_lc = lc;
    while (b_stopin === 1'b1 && w < 100) begin @(posedge clk); #1; w++; end
    if (w >= 100) check("b_beat_timeout", 64'(w), 64'd0);
    @(posedge clk); #1;
    b_push = 1'b0; b_last = 1'b0;
  endtask

  task automatic beat_c(input logic [3:0] d, input logic l, input logic [1:0] lc);
    int w = 0;
    c_push = 1'b1; c_din = d; c_last = l; c_lc = lc;
    while (c_stopin === 1'b1 && w < 100) begin @(posedge clk); #1; w++; end
    if (w >= 100) check("c_beat_timeout", 64'(w), 64'd0);
    @(posedge clk); #1;
    c_push = 1'b0; c_last = 1'b0;
  endtask

  // Send n bits on instance a, bits[n-1] first, closing on the last one.
  task automatic send_a(input logic [127:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) beat_a(bits[i], (i == 0));
  endtask

  task automatic drain_all();
    int w = 0;
    a_pull = 1'b1; b_pull = 1'b1; c_pull = 1'b1;
    while (!(qa.size() == 0 && qb.size() == 0 && qc.size() == 0 &&
             a_stopout === 1'b1 && b_stopout === 1'b1 && c_stopout === 1'b1) && w < 300) begin
      @(posedge clk); #1; w++;
    end
    check("drain_done", 64'(w < 300), 64'd1);
    a_pull = 1'b0; b_pull = 1'b0; c_pull = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v64;
    rst = 1'b0;
    a_push = 1'b0; a_last = 1'b0; a_din = 1'b0; a_lc = 1'b0; a_pull = 1'b0;
    b_push = 1'b0; b_last = 1'b0; b_din = 4'h0; b_lc = 2'd0; b_pull = 1'b0;
    c_push = 1'b0; c_last = 1'b0; c_din = 4'h0; c_lc = 2'd0; c_pull = 1'b0;
    #12;
    // Reset state
    check("rst_a_stopin",  64'(a_stopin),  64'd0);
    check("rst_a_stopout", 64'(a_stopout), 64'd1);
    check("rst_a_dataout", a_dout,         64'd0);
    check("rst_a_lenout",  64'(a_len),     64'd0);
    check("rst_a_count",   64'(a_cnt),     64'd0);
    check("rst_a_errlen",  64'(a_err),     64'd0);
    check("rst_c_stopout", 64'(c_stopout), 64'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // 7 bits 1011001 MSB-first with pullout held: one transfer of 0x59/7.
    a_pull = 1'b1;
    qa.push_back(mk(64'h59, 7));
    send_a(128'b1011001, 7);
    check("a_latency_not_yet", 64'(a_stopout), 64'd1);
    @(posedge clk); #1;
    check("a_latency_present", 64'(a_stopout), 64'd0);
    drain_all();

    // Multi-lane MSB-first, with random pullout while streaming.
    qb.push_back(mk(64'h28F, 10));
    qb.push_back(mk(64'h1, 1));
    qb.push_back(mk(64'h3, 3));
    qb.push_back(mk(64'h0123456789ABCDEF, 64));
    qb.push_back(mk(64'hA, 4));
    qb.push_back(mk(64'h5, 4));
    v64 = 64'h0123456789ABCDEF;
    tog_b = 1'b1;
    fork
      begin
        beat_b(4'hA, 1'b0, 2'd0);
        beat_b(4'h3, 1'b0, 2'd0);
        beat_b(4'hC, 1'b1, 2'd1);
        beat_b(4'b1000, 1'b1, 2'd0);
        beat_b(4'b0111, 1'b1, 2'd2);
        for (int i = 15; i >= 0; i--) beat_b(v64[i*4 +: 4], (i == 0), 2'd3);
        beat_b(4'hA, 1'b1, 2'd3);
        beat_b(4'h5, 1'b1, 2'd3);
        tog_b = 1'b0;
      end
      begin
        while (tog_b) begin @(posedge clk); #1; b_pull = 1'($urandom_range(0, 1)); end
      end
    join
    drain_all();
    check("b_errlen_exact64", 64'(b_err), 64'd0);

    // Fill a (DEPTH=4) with pullout low; 5th beat must be held.
    qa.push_back(mk(64'h1, 1));
    qa.push_back(mk(64'h0, 1));
    qa.push_back(mk(64'h1, 1));
    qa.push_back(mk(64'h1, 1));
    qa.push_back(mk(64'h0, 1));
    beat_a(1'b1, 1'b1);
    beat_a(1'b0, 1'b1);
    beat_a(1'b1, 1'b1);
    beat_a(1'b1, 1'b1);
    check("a_full_count",  64'(a_cnt),    64'd4);
    check("a_full_stopin", 64'(a_stopin), 64'd1);
    fork
      beat_a(1'b0, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("a_held_count",  64'(a_cnt),    64'd4);
        check("a_held_stopin", 64'(a_stopin), 64'd1);
        a_pull = 1'b1;
        @(posedge clk); #1;
        a_pull = 1'b0;
        check("a_pull_count",  64'(a_cnt),    64'd3);
        check("a_pull_stopin", 64'(a_stopin), 64'd0);
      end
    join
    check("a_refill_count",  64'(a_cnt),    64'd4);
    check("a_refill_stopin", 64'(a_stopin), 64'd1);
    drain_all();
    check("a_empty_count", 64'(a_cnt), 64'd0);

    // 70-bit message on MAXLEN=64, then a good one; errlen stays set.
    check("a_errlen_clean", 64'(a_err), 64'd0);
    a_pull = 1'b1;
    qa.push_back(mk(64'hDEADBEEF01234567, 64));
    qa.push_back(mk(64'h6, 3));
    send_a({58'd0, 64'hDEADBEEF01234567, 6'b101010}, 70);
    send_a(128'b110, 3);
    drain_all();
    check("a_errlen_sticky", 64'(a_err), 64'd1);

    // LSB-first, MAXLEN=8, DEPTH=3.
    c_pull = 1'b1;
    qc.push_back(mk(64'hC5, 8));
    beat_c(4'hA, 1'b0, 2'd0);
    beat_c(4'h3, 1'b1, 2'd3);
    drain_all();
    check("c_errlen_exact8", 64'(c_err), 64'd0);
    qc.push_back(mk(64'hC5, 8));
    qc.push_back(mk(64'h3, 3));
    qc.push_back(mk(64'h8, 4));
    qc.push_back(mk(64'h4, 4));
    qc.push_back(mk(64'hC, 4));
    qc.push_back(mk(64'h6, 4));
    qc.push_back(mk(64'h7, 4));
    qc.push_back(mk(64'h1, 4));
    tog_c = 1'b1;
    fork
      begin
        beat_c(4'hA, 1'b0, 2'd0);
        beat_c(4'h3, 1'b0, 2'd0);
        beat_c(4'hC, 1'b1, 2'd3);
        beat_c(4'b1101, 1'b1, 2'd2);
        beat_c(4'h1, 1'b1, 2'd3);
        beat_c(4'h2, 1'b1, 2'd3);
        beat_c(4'h3, 1'b1, 2'd3);
        beat_c(4'h6, 1'b1, 2'd3);
        beat_c(4'hE, 1'b1, 2'd3);
        beat_c(4'h8, 1'b1, 2'd3);
        tog_c = 1'b0;
      end
      begin
        while (tog_c) begin @(posedge clk); #1; c_pull = 1'($urandom_range(0, 1)); end
      end
    join
    drain_all();
    check("c_errlen_sticky", 64'(c_err), 64'd1);
    qc.push_back(mk(64'h8, 4));
    qc.push_back(mk(64'h4, 4));
    qc.push_back(mk(64'hC, 4));
    beat_c(4'h1, 1'b1, 2'd3);
    beat_c(4'h2, 1'b1, 2'd3);
    beat_c(4'h3, 1'b1, 2'd3);
    check("c_full_count",  64'(c_cnt),    64'd3);
    check("c_full_stopin", 64'(c_stopin), 64'd1);
    drain_all();

    // Reset mid-message with two messages queued: all of it is discarded.
    beat_a(1'b1, 1'b1);
    beat_a(1'b0, 1'b1);
    beat_a(1'b1, 1'b0);
    beat_a(1'b1, 1'b0);
    check("a_pre_reset_count", 64'(a_cnt), 64'd2);
    rst = 1'b0;
    #1;
    check("a_mid_rst_stopout", 64'(a_stopout), 64'd1);
    check("a_mid_rst_count",   64'(a_cnt),     64'd0);
    check("a_mid_rst_errlen",  64'(a_err),     64'd0);
    check("a_mid_rst_dataout", a_dout,         64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    a_pull = 1'b1;
    qa.push_back(mk(64'h5, 3));
    send_a(128'b101, 3);
    drain_all();
    repeat (4) @(posedge clk);
    #1;
    check("a_final_count", 64'(a_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
